// File: rtl/keypad_entry_ctrl.sv
// Keypad front end for the ATM stage: assembles a 4-digit account number and
// a 1-digit PIN, hands them off for authentication, and tracks session/lockout.
module keypad_entry_ctrl #(
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int MAX_TRIES      = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  input  logic        auth_done,
  input  logic        auth_ok,
  input  logic        session_end,
  output logic [11:0] acc_number,
  output logic [3:0]  pin,
  output logic        cred_valid,
  output logic        session_active,
  output logic        locked,
  output logic        entry_error,
  output logic        timeout,
  output logic [2:0]  digit_count
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int FW = $clog2(MAX_TRIES + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ACC, S_PIN, S_SUBMIT, S_SESSION, S_LOCKED
  } state_t;

  state_t        state;
  logic [13:0]   acc;
  logic [TW-1:0] idle_cnt;
  logic [FW-1:0] fail_cnt;

  logic        is_digit, is_clear, is_enter, is_cancel, is_illegal;
  logic        in_entry, sub_auth, idle_hit, cancel_go, tmo_go, end_go;
  logic [13:0] acc_shift;

  assign is_digit   = (key_code <= 4'd9);
  assign is_clear   = (key_code == 4'hA);
  assign is_enter   = (key_code == 4'hB);
  assign is_cancel  = (key_code == 4'hC);
  assign is_illegal = (key_code >= 4'hD);

  // At most 3 digits are held when a new one is shifted in, so 14 bits never overflow.
  assign acc_shift = acc * 14'd10 + {10'd0, key_code};

  assign in_entry = (state == S_ACC) || (state == S_PIN) || (state == S_SUBMIT);
  assign sub_auth = (state == S_SUBMIT) && auth_done;
  assign idle_hit = (idle_cnt == TW'(TIMEOUT_CYCLES - 1));

  // Abandon paths all land in IDLE with every field cleared; a pending
  // authentication result outranks both, and any key suppresses the timeout.
  assign cancel_go = in_entry && key_valid && is_cancel && !sub_auth;
  assign tmo_go    = in_entry && !key_valid && idle_hit && !sub_auth;
  assign end_go    = (state == S_SESSION) && session_end;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      acc            <= '0;
      acc_number     <= '0;
      pin            <= '0;
      digit_count    <= '0;
      idle_cnt       <= '0;
      fail_cnt       <= '0;
      cred_valid     <= 1'b0;
      session_active <= 1'b0;
      locked         <= 1'b0;
      entry_error    <= 1'b0;
      timeout        <= 1'b0;
    end else begin
      cred_valid  <= 1'b0;
      entry_error <= 1'b0;
      timeout     <= 1'b0;
      if (key_valid || !in_entry) idle_cnt <= '0;
      else                        idle_cnt <= idle_cnt + TW'(1);

      case (state)
        S_IDLE: begin
          if (key_valid && is_digit) begin
            acc         <= {10'd0, key_code};
            digit_count <= 3'd1;
            state       <= S_ACC;
          end
        end
        S_ACC: begin
          if (key_valid) begin
            if (is_digit) begin
              if (digit_count < 3'd4) begin
                acc         <= acc_shift;
                digit_count <= digit_count + 3'd1;
              end else begin
                entry_error <= 1'b1;
              end
            end else if (is_enter) begin
              if (digit_count == 3'd4 && acc <= 14'd4095) begin
                acc_number  <= acc[11:0];
                acc         <= '0;
                pin         <= '0;
                digit_count <= '0;
                state       <= S_PIN;
              end else begin
                entry_error <= 1'b1;
                acc         <= '0;
                digit_count <= '0;
              end
            end else if (is_clear) begin
              acc         <= '0;
              digit_count <= '0;
            end else if (is_illegal) begin
              entry_error <= 1'b1;
            end
          end
        end
        S_PIN: begin
          if (key_valid) begin
            if (is_digit) begin
              if (digit_count == 3'd0) begin
                pin         <= key_code;
                digit_count <= 3'd1;
              end else begin
                entry_error <= 1'b1;
              end
            end else if (is_enter) begin
              if (digit_count == 3'd1) begin
                cred_valid <= 1'b1;
                state      <= S_SUBMIT;
              end else begin
                entry_error <= 1'b1;
              end
            end else if (is_clear) begin
              pin         <= '0;
              digit_count <= '0;
            end else if (is_illegal) begin
              entry_error <= 1'b1;
            end
          end
        end
        S_SUBMIT: begin
          if (auth_done) begin
            idle_cnt <= '0;
            if (auth_ok) begin
              session_active <= 1'b1;
              fail_cnt       <= '0;
              state          <= S_SESSION;
            end else if (fail_cnt >= FW'(MAX_TRIES - 1)) begin
              fail_cnt <= fail_cnt + FW'(1);
              locked   <= 1'b1;
              state    <= S_LOCKED;
            end else begin
              fail_cnt    <= fail_cnt + FW'(1);
              pin         <= '0;
              digit_count <= '0;
              state       <= S_PIN;
            end
          end
        end
        S_SESSION: ;
        S_LOCKED:  ;
        default:   state <= S_IDLE;
      endcase

      if (cancel_go || tmo_go || end_go) begin
        acc            <= '0;
        acc_number     <= '0;
        pin            <= '0;
        digit_count    <= '0;
        idle_cnt       <= '0;
        session_active <= 1'b0;
        timeout        <= tmo_go;
        state          <= S_IDLE;
      end
    end
  end

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// Directed bench for keypad_entry_ctrl: entry, validation, auth, lockout, timeout.
module tb_keypad_entry_ctrl;
  localparam int T = 20;
  localparam int M = 3;
  localparam logic [3:0] K_CLR = 4'hA, K_ENT = 4'hB, K_CAN = 4'hC, K_ILL = 4'hE;

  logic        clk = 1'b0, rst_n, key_valid, auth_done, auth_ok, session_end;
  logic [3:0]  key_code;
  logic [11:0] acc_number;
  logic [3:0]  pin;
  logic        cred_valid, session_active, locked, entry_error, timeout;
  logic [2:0]  digit_count;
  int compared = 0, mismatched = 0;

  keypad_entry_ctrl #(.TIMEOUT_CYCLES(T), .MAX_TRIES(M)) dut (
    .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_code(key_code),
    .auth_done(auth_done), .auth_ok(auth_ok), .session_end(session_end),
    .acc_number(acc_number), .pin(pin), .cred_valid(cred_valid),
    .session_active(session_active), .locked(locked), .entry_error(entry_error),
    .timeout(timeout), .digit_count(digit_count));

  always #5 clk = ~clk;

  // All stimulus tasks start and end on a negedge; outputs are sampled there.
  task automatic press(input logic [3:0] k);
    key_code = k; key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0; key_code = 4'd0;
  endtask

  task automatic press_seq(input logic [15:0] seq, input int n);
    for (int i = n - 1; i >= 0; i--) press(seq[i*4 +: 4]);
  endtask

  task automatic auth(input logic ok);
    auth_done = 1'b1; auth_ok = ok;
    @(negedge clk);
    auth_done = 1'b0; auth_ok = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic apply_reset;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    key_valid = 0; key_code = 0; auth_done = 0; auth_ok = 0; session_end = 0;
    rst_n = 1'b0;
    idle(2);
    compared++; if ({acc_number, pin, cred_valid, session_active, locked, entry_error, timeout, digit_count} !== 24'd0) begin
      mismatched++; $display("FAIL reset_outputs: got %h want 0", {acc_number, pin, cred_valid, session_active, locked, entry_error, timeout, digit_count}); end
    rst_n = 1'b1;
    idle(1);
  endtask

  task automatic test_happy_path;
    apply_reset();
    press_seq(16'h2749, 4);
    compared++; if (digit_count !== 3'd4) begin mismatched++; $display("FAIL happy_dc4: got %0d want 4", digit_count); end
    press(K_ENT);
    compared++; if (acc_number !== 12'd2749) begin mismatched++; $display("FAIL happy_acc: got %0d want 2749", acc_number); end
    compared++; if (digit_count !== 3'd0 || cred_valid !== 1'b0) begin mismatched++; $display("FAIL happy_acc_enter: dc %0d cv %0d want 0 0", digit_count, cred_valid); end
    press(4'd0);
    compared++; if (digit_count !== 3'd1) begin mismatched++; $display("FAIL happy_pin_dc: got %0d want 1", digit_count); end
    press(K_ENT);
    compared++; if (cred_valid !== 1'b1 || pin !== 4'd0) begin mismatched++; $display("FAIL happy_cred: cv %0d pin %0d want 1 0", cred_valid, pin); end
    idle(1);
    compared++; if (cred_valid !== 1'b0) begin mismatched++; $display("FAIL happy_cred_pulse: got %0d want 0", cred_valid); end
    auth(1'b1);
    compared++; if (session_active !== 1'b1) begin mismatched++; $display("FAIL happy_session: got %0d want 1", session_active); end
    press(4'd5);
    compared++; if (digit_count !== 3'd1 || acc_number !== 12'd2749) begin mismatched++; $display("FAIL session_keys_ignored: dc %0d acc %0d want 1 2749", digit_count, acc_number); end
    session_end = 1'b1; idle(1); session_end = 1'b0;
    compared++; if (session_active !== 1'b0 || acc_number !== 12'd0 || digit_count !== 3'd0) begin
      mismatched++; $display("FAIL session_end: sa %0d acc %0d dc %0d want 0 0 0", session_active, acc_number, digit_count); end
  endtask

  task automatic test_acc_range;
    apply_reset();
    press_seq(16'h5000, 4);
    press(K_ENT);
    compared++; if (entry_error !== 1'b1 || digit_count !== 3'd0 || acc_number !== 12'd0) begin
      mismatched++; $display("FAIL acc_over_4095: err %0d dc %0d acc %0d want 1 0 0", entry_error, digit_count, acc_number); end
    idle(1);
    compared++; if (entry_error !== 1'b0) begin mismatched++; $display("FAIL err_pulse: got %0d want 0", entry_error); end
    press_seq(16'h4095, 4);
    press(K_ENT);
    compared++; if (acc_number !== 12'd4095 || entry_error !== 1'b0) begin mismatched++; $display("FAIL acc_4095: acc %0d err %0d want 4095 0", acc_number, entry_error); end
  endtask

  task automatic test_digit_limits;
    apply_reset();
    press_seq(16'h0021, 2);
    press(K_ENT);
    compared++; if (entry_error !== 1'b1 || digit_count !== 3'd0) begin mismatched++; $display("FAIL short_acc: err %0d dc %0d want 1 0", entry_error, digit_count); end
    press_seq(16'h2175, 4);
    press(4'd8);
    compared++; if (entry_error !== 1'b1 || digit_count !== 3'd4) begin mismatched++; $display("FAIL fifth_digit: err %0d dc %0d want 1 4", entry_error, digit_count); end
    press(K_ENT);
    compared++; if (acc_number !== 12'd2175) begin mismatched++; $display("FAIL acc_2175: got %0d want 2175", acc_number); end
  endtask

  // Continues from PIN entry with acc_number 2175 left by test_digit_limits.
  task automatic test_pin_edit;
    press(K_ENT);
    compared++; if (entry_error !== 1'b1 || cred_valid !== 1'b0) begin mismatched++; $display("FAIL pin_empty_enter: err %0d cv %0d want 1 0", entry_error, cred_valid); end
    press(4'd3);
    compared++; if (pin !== 4'd3 || digit_count !== 3'd1) begin mismatched++; $display("FAIL pin_digit: pin %0d dc %0d want 3 1", pin, digit_count); end
    press(4'd8);
    compared++; if (entry_error !== 1'b1 || pin !== 4'd3) begin mismatched++; $display("FAIL pin_second: err %0d pin %0d want 1 3", entry_error, pin); end
    press(K_CLR);
    compared++; if (pin !== 4'd0 || digit_count !== 3'd0 || acc_number !== 12'd2175) begin
      mismatched++; $display("FAIL pin_clear: pin %0d dc %0d acc %0d want 0 0 2175", pin, digit_count, acc_number); end
    press(4'd7);
    press(K_ILL);
    compared++; if (entry_error !== 1'b1 || pin !== 4'd7 || digit_count !== 3'd1) begin
      mismatched++; $display("FAIL pin_illegal: err %0d pin %0d dc %0d want 1 7 1", entry_error, pin, digit_count); end
    session_end = 1'b1; idle(1); session_end = 1'b0;
    compared++; if (pin !== 4'd7 || acc_number !== 12'd2175 || digit_count !== 3'd1) begin
      mismatched++; $display("FAIL pin_session_end: pin %0d acc %0d dc %0d want 7 2175 1", pin, acc_number, digit_count); end
    press(K_ENT);
    compared++; if (cred_valid !== 1'b1) begin mismatched++; $display("FAIL pin_cred: got %0d want 1", cred_valid); end
    press(4'd5);
    compared++; if (entry_error !== 1'b0 || pin !== 4'd7) begin mismatched++; $display("FAIL submit_ignore: err %0d pin %0d want 0 7", entry_error, pin); end
    key_code = K_CAN; key_valid = 1'b1; auth_done = 1'b1; auth_ok = 1'b1;
    idle(1);
    key_valid = 1'b0; auth_done = 1'b0; auth_ok = 1'b0;
    compared++; if (session_active !== 1'b1 || acc_number !== 12'd2175) begin
      mismatched++; $display("FAIL auth_over_cancel: sa %0d acc %0d want 1 2175", session_active, acc_number); end
  endtask

  task automatic test_cancel;
    apply_reset();
    press_seq(16'h1234, 4); press(K_ENT); press(4'd9); press(K_ENT);
    press(K_CAN);
    compared++; if (acc_number !== 12'd0 || pin !== 4'd0 || digit_count !== 3'd0) begin
      mismatched++; $display("FAIL submit_cancel: acc %0d pin %0d dc %0d want 0 0 0", acc_number, pin, digit_count); end
    press(K_ENT);
    compared++; if (entry_error !== 1'b0) begin mismatched++; $display("FAIL idle_enter_ignored: got %0d want 0", entry_error); end
  endtask

  task automatic test_lockout;
    apply_reset();
    press_seq(16'h1234, 4); press(K_ENT); press(4'd6); press(K_ENT);
    auth(1'b0);
    compared++; if (locked !== 1'b0 || pin !== 4'd0 || digit_count !== 3'd0 || acc_number !== 12'd1234) begin
      mismatched++; $display("FAIL fail1: lk %0d pin %0d dc %0d acc %0d want 0 0 0 1234", locked, pin, digit_count, acc_number); end
    press(4'd6); press(K_ENT);
    compared++; if (cred_valid !== 1'b1) begin mismatched++; $display("FAIL fail1_repin: got %0d want 1", cred_valid); end
    auth(1'b0);
    compared++; if (locked !== 1'b0) begin mismatched++; $display("FAIL fail2: got %0d want 0", locked); end
    press(4'd6); press(K_ENT);
    auth(1'b0);
    compared++; if (locked !== 1'b1) begin mismatched++; $display("FAIL fail3_lock: got %0d want 1", locked); end
    press(4'd5); press(K_CAN); auth(1'b1); idle(2 * T);
    compared++; if (locked !== 1'b1 || pin !== 4'd6 || acc_number !== 12'd1234 || session_active !== 1'b0 || timeout !== 1'b0) begin
      mismatched++; $display("FAIL locked_hold: lk %0d pin %0d acc %0d sa %0d to %0d want 1 6 1234 0 0", locked, pin, acc_number, session_active, timeout); end
    #2 rst_n = 1'b0;
    #1;
    compared++; if (locked !== 1'b0 || acc_number !== 12'd0 || pin !== 4'd0) begin
      mismatched++; $display("FAIL async_reset: lk %0d acc %0d pin %0d want 0 0 0", locked, acc_number, pin); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_timeout;
    apply_reset();
    press_seq(16'h0024, 2);
    idle(T - 1);
    compared++; if (timeout !== 1'b0 || digit_count !== 3'd2) begin mismatched++; $display("FAIL to_early: to %0d dc %0d want 0 2", timeout, digit_count); end
    idle(1);
    compared++; if (timeout !== 1'b1 || digit_count !== 3'd0) begin mismatched++; $display("FAIL to_fire: to %0d dc %0d want 1 0", timeout, digit_count); end
    idle(1);
    compared++; if (timeout !== 1'b0) begin mismatched++; $display("FAIL to_pulse: got %0d want 0", timeout); end
    press_seq(16'h0024, 2);
    idle(T - 1);
    press(4'd5);
    compared++; if (timeout !== 1'b0 || digit_count !== 3'd3) begin mismatched++; $display("FAIL to_key_wins: to %0d dc %0d want 0 3", timeout, digit_count); end
    idle(T - 1);
    compared++; if (timeout !== 1'b0) begin mismatched++; $display("FAIL to_restart_early: got %0d want 0", timeout); end
    idle(1);
    compared++; if (timeout !== 1'b1) begin mismatched++; $display("FAIL to_restart_fire: got %0d want 1", timeout); end
  endtask

  task automatic test_timeout_keeps_fails;
    apply_reset();
    press_seq(16'h1234, 4); press(K_ENT); press(4'd1); press(K_ENT); auth(1'b0);
    press(4'd1); press(K_ENT); auth(1'b0);
    idle(T - 1);
    idle(1);
    compared++; if (timeout !== 1'b1 || acc_number !== 12'd0) begin mismatched++; $display("FAIL pin_timeout: to %0d acc %0d want 1 0", timeout, acc_number); end
    press_seq(16'h1234, 4); press(K_ENT); press(4'd1); press(K_ENT); auth(1'b0);
    compared++; if (locked !== 1'b1) begin mismatched++; $display("FAIL fails_kept: got %0d want 1", locked); end
  endtask

  initial begin
    test_reset();
    test_happy_path();
    test_acc_range();
    test_digit_limits();
    test_pin_edit();
    test_cancel();
    test_lockout();
    test_timeout();
    test_timeout_keeps_fails();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/keypad_entry_ctrl.md
KEYPAD_ENTRY_CTRL -- requirements
Module: keypad_entry_ctrl

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 1000, idle cycles before an entry is abandoned.
REQ-002 Parameter: MAX_TRIES, default 3, failed authentications before lockout.
REQ-003 Ports: clk  in  1  single clock, all state updates on posedge clk.
REQ-004 Ports: rst_n  in  1  asynchronous, active-low reset.
REQ-005 Ports: key_valid  in  1  one-cycle strobe qualifying key_code.
REQ-006 Ports: key_code  in  4  0-9 digit, 0xA CLEAR, 0xB ENTER, 0xC CANCEL, 0xD-0xF illegal.
REQ-007 Ports: auth_done  in  1  one-cycle authentication result strobe from the ATM stage.
REQ-008 Ports: auth_ok  in  1  result, qualified by auth_done.
REQ-009 Ports: session_end  in  1  user exit from the ATM stage.
REQ-010 Ports: acc_number  out  12  assembled account number, feeds the ATM stage.
REQ-011 Ports: pin  out  4  assembled PIN, feeds the ATM stage.
REQ-012 Ports: cred_valid  out  1  one-cycle pulse, credentials ready.
REQ-013 Ports: session_active  out  1  high while authenticated.
REQ-014 Ports: locked  out  1  lockout indicator.
REQ-015 Ports: entry_error  out  1  one-cycle pulse on a rejected key or entry.
REQ-016 Ports: timeout  out  1  one-cycle pulse on inactivity abandon.
REQ-017 Ports: digit_count  out  3  digits entered in the current field.

Function
REQ-018 States SHALL be IDLE, ACC, PIN, SUBMIT, SESSION, LOCKED.
REQ-019 IDLE: a digit key SHALL load the accumulator with that digit, set digit_count=1, and go to ACC; other keys SHALL be ignored without an error.
REQ-020 ACC digit: while digit_count<4, accumulator (14 bits) SHALL become acc*10+digit and digit_count SHALL increment; a 5th digit SHALL be dropped with entry_error.
REQ-021 ACC ENTER: with digit_count==4 and value<=4095, the low 12 bits SHALL latch into acc_number, digit_count SHALL clear, and the FSM SHALL go to PIN.
REQ-022 ACC ENTER otherwise (fewer than 4 digits or value>4095): entry_error SHALL pulse and the field SHALL clear, staying in ACC.
REQ-023 PIN: exactly one digit SHALL be accepted into pin; a 2nd digit SHALL be dropped with entry_error.
REQ-024 PIN ENTER with one digit: cred_valid SHALL pulse the next cycle and the FSM SHALL go to SUBMIT; ENTER with no digit SHALL pulse entry_error.
REQ-025 CLEAR SHALL clear only the current field (ACC or PIN) and digit_count.
REQ-026 CANCEL in ACC, PIN or SUBMIT SHALL clear all fields and return to IDLE.
REQ-027 Illegal codes 0xD-0xF SHALL pulse entry_error with no state change.
REQ-028 SUBMIT: key_valid SHALL be ignored except CANCEL; auth_done SHALL take priority over a same-cycle key.
REQ-029 SUBMIT, auth_done&auth_ok: go to SESSION, set session_active, clear the fail counter.
REQ-030 SUBMIT, auth_done&!auth_ok: increment the fail counter; on reaching MAX_TRIES go to LOCKED, else clear pin and return to PIN with acc_number kept.
REQ-031 SESSION: acc_number and pin SHALL be held stable and keys ignored; session_end SHALL clear all fields and return to IDLE.
REQ-032 session_end SHALL be ignored outside SESSION.
REQ-033 Inactivity counter SHALL reset on every key_valid and on each state change.
REQ-034 Inactivity counter SHALL count in ACC, PIN and SUBMIT.
REQ-035 On the count reaching TIMEOUT_CYCLES: timeout SHALL pulse, fields SHALL clear, the FSM SHALL go to IDLE, and the fail counter SHALL be kept.
REQ-036 If a timeout and a key occur in the same cycle, the key SHALL win and the counter SHALL reset.
REQ-037 LOCKED: locked=1, all inputs ignored; exit only via rst_n.
REQ-038 cred_valid, entry_error and timeout SHALL be registered single-cycle pulses.
REQ-039 At most one of cred_valid, entry_error and timeout SHALL be high per cycle.

Reset
REQ-040 rst_n low SHALL immediately force IDLE and clear every output, the accumulator, the fail counter and the inactivity counter, including mid-entry and in LOCKED.

Verification
REQ-041 Keys 2,7,4,9,ENTER,0,ENTER -> acc_number=2749, pin=0, cred_valid one pulse the cycle after the last ENTER; auth_done&auth_ok -> session_active=1.
REQ-042 Keys 5,0,0,0,ENTER -> entry_error pulse, digit_count=0, still ACC.
REQ-043 Keys 2,1 then ENTER -> entry_error pulse; keys 2,1,7,5,8 -> 5th digit rejected with entry_error, acc_number=2175 after ENTER.
REQ-044 Three auth_done with auth_ok=0 -> PIN after the 1st and 2nd, locked=1 after the 3rd; keys ignored; rst_n pulse -> IDLE, locked=0.
REQ-045 Keys 2,4 then TIMEOUT_CYCLES idle cycles -> timeout pulse, IDLE, digit_count=0; a key on the terminal cycle prevents the timeout.
REQ-046 In SESSION, session_end -> IDLE, outputs cleared; session_end in PIN -> no effect.
